jpeg_bitmap_writer: RTL and testbench

Downstream stage of `jpeg_decode`: accepts the decoder's per-pixel output strobe (coordinates, RGB, image dimensions) and turns each pixel into a 32-bit word write to a linear frame buffer. Addressing is `BaseAddr + y*width + x`. A small FIFO absorbs memory-port stalls, because the decoder has no back-pressure input. The block also reports frame completion, pixel count and error flags to the PCI-side status logic.

---
 rtl/djpeg_pkg.sv | 11 +
 rtl/bm_sync_fifo.sv | 33 +++
 rtl/jpeg_bitmap_writer.sv | 100 ++++++++++
 tb/tb_jpeg_bitmap_writer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/djpeg_pkg.sv
// djpeg_pkg: shared types, widths and helpers for the JPEG frame-buffer writer.
package djpeg_pkg;
  localparam int DATA_W = 32;
  typedef enum logic {IDLE, REQ} wr_state_t;
  function automatic int entry_w(int aw);
    return 1 + aw + DATA_W;
  endfunction
  function automatic logic [DATA_W-1:0] pack_rgb(logic [7:0] r, logic [7:0] g, logic [7:0] b);
    return {8'h00, r, g, b};
  endfunction
endpackage

// File: rtl/bm_sync_fifo.sv
// bm_sync_fifo: single-clock FIFO with extra-MSB pointers for full/empty detection.
module bm_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign count = wptr - rptr;
  assign empty = wptr == rptr;
  assign full = wptr == {~rptr[AW], rptr[AW-1:0]};
  assign rd_data = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en && !full) wptr <= wptr + (AW+1)'(1);
      if (rd_en && !empty) rptr <= rptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (wr_en && !full) mem[wptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/jpeg_bitmap_writer.sv
// jpeg_bitmap_writer: turns decoder pixel strobes into buffered frame-buffer word writes.
module jpeg_bitmap_writer
  import djpeg_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InEnable,
  input  logic [15:0]       InWidth,
  input  logic [15:0]       InHeight,
  input  logic [15:0]       InPixelX,
  input  logic [15:0]       InPixelY,
  input  logic [7:0]        InR,
  input  logic [7:0]        InG,
  input  logic [7:0]        InB,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic              ClearStatus,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemData,
  input  logic              MemAck,
  output logic              FrameDone,
  output logic [23:0]       PixelCount,
  output logic              Overflow,
  output logic              RangeErr,
  output logic              Busy
);
  localparam int EW = entry_w(ADDR_W);
  logic v0, v1, in_range1, last1, last_q, full, empty, push, pop, ack, ovf_set, rng_set;
  logic [15:0] w0, h0, x0, y0;
  logic [7:0] r0, g0, b0;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0] data1;
  logic [EW-1:0] head;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  wr_state_t state;
  // 32-bit row product, then truncated to the frame-buffer address width
  assign addr0 = ADDR_W'(32'(y0) * 32'(w0) + 32'(x0) + 32'(BaseAddr));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      {w0, h0, x0, y0, r0, g0, b0} <= '0;
      {in_range1, last1, addr1, data1} <= '0;
    end else begin
      v0 <= InEnable;
      v1 <= v0;
      if (InEnable) {w0, h0, x0, y0, r0, g0, b0} <= {InWidth, InHeight, InPixelX, InPixelY, InR, InG, InB};
      if (v0) begin
        in_range1 <= x0 < w0 && y0 < h0;
        last1 <= x0 == w0 - 16'd1 && y0 == h0 - 16'd1;
        addr1 <= addr0;
        data1 <= pack_rgb(r0, g0, b0);
      end
    end
  assign rng_set = v1 && !in_range1;
  assign ovf_set = v1 && in_range1 && full;
  assign push = v1 && in_range1 && !full;
  assign ack = state == REQ && MemAck;
  assign pop = !empty && (state == IDLE || MemAck);
  assign Busy = v0 || v1 || fifo_cnt != '0 || MemReq;
  bm_sync_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(push),
    .wr_data({last1, addr1, data1}),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(fifo_cnt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      MemReq <= 1'b0;
      MemAddr <= '0;
      MemData <= '0;
      last_q <= 1'b0;
      FrameDone <= 1'b0;
      PixelCount <= '0;
      Overflow <= 1'b0;
      RangeErr <= 1'b0;
    end else begin
      FrameDone <= ack && last_q;
      PixelCount <= ack ? (ClearStatus ? 24'd1 : PixelCount + 24'd1) : (ClearStatus ? '0 : PixelCount);
      Overflow <= ovf_set || (Overflow && !ClearStatus);
      RangeErr <= rng_set || (RangeErr && !ClearStatus);
      if (pop) begin
        {last_q, MemAddr, MemData} <= head;
        MemReq <= 1'b1;
        state <= REQ;
      end else if (ack) begin
        MemReq <= 1'b0;
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_jpeg_bitmap_writer.sv
// tb_jpeg_bitmap_writer: directed table vectors plus multi-cycle sequences for the bitmap writer.
module tb_jpeg_bitmap_writer;
  logic clk = 1'b0, rst = 1'b0;
  logic InEnable = 1'b0, ClearStatus = 1'b0, MemAck = 1'b0;
  logic [15:0] InWidth = '0, InHeight = '0, InPixelX = '0, InPixelY = '0;
  logic [7:0] InR = '0, InG = '0, InB = '0;
  logic [19:0] BaseAddr = '0;
  logic MemReq, FrameDone, Overflow, RangeErr, Busy;
  logic [19:0] MemAddr;
  logic [31:0] MemData;
  logic [23:0] PixelCount;
  int checks = 0, errors = 0, cyc = 0;
  logic [19:0] wa[$];
  logic [31:0] wd[$];
  int wc[$], fd[$];
  logic hold = 1'b0;
  logic [19:0] h_addr;
  logic [31:0] h_data;

  jpeg_bitmap_writer dut (
    .clk(clk), .rst(rst), .InEnable(InEnable), .InWidth(InWidth), .InHeight(InHeight),
    .InPixelX(InPixelX), .InPixelY(InPixelY), .InR(InR), .InG(InG), .InB(InB),
    .BaseAddr(BaseAddr), .ClearStatus(ClearStatus), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemData(MemData), .MemAck(MemAck), .FrameDone(FrameDone), .PixelCount(PixelCount),
    .Overflow(Overflow), .RangeErr(RangeErr), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // write log, FrameDone log and request-stability watch, all sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (MemReq && MemAck) begin
      wa.push_back(MemAddr);
      wd.push_back(MemData);
      wc.push_back(cyc);
    end
    if (FrameDone) fd.push_back(cyc);
    if (rst && hold) begin
      checks++;
      if (!MemReq || MemAddr !== h_addr || MemData !== h_data) begin
        errors++;
        $display("FAIL hold_stable: got req=%0b addr=0x%0h data=0x%0h expected req=1 addr=0x%0h data=0x%0h",
                 MemReq, MemAddr, MemData, h_addr, h_data);
      end
    end
    hold = rst && MemReq && !MemAck;
    h_addr = MemAddr;
    h_data = MemData;
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, y, w, h, input logic [23:0] rgb);
    {InPixelX, InPixelY, InWidth, InHeight} = {x, y, w, h};
    {InR, InG, InB} = rgb;
    InEnable = 1'b1;
    step();
    InEnable = 1'b0;
  endtask

  task automatic clear_status();
    ClearStatus = 1'b1;
    step();
    ClearStatus = 1'b0;
  endtask

  task automatic clear_logs();
    wa.delete();
    wd.delete();
    wc.delete();
    fd.delete();
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (Busy && n < max) begin
      step();
      n++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", max);
    end
    repeat (2) step();
  endtask

  typedef struct {
    logic [15:0] x, y, w, h;
    logic [23:0] rgb;
    logic [19:0] base;
    int nwr;
    logic [19:0] addr;
    logic [31:0] data;
    logic rerr;
    int nfd;
  } vec_t;
  vec_t vt[7];

  initial begin
    vt[0] = '{16'd3, 16'd2, 16'd16, 16'd16, 24'h123456, 20'h01000, 1, 20'h01023, 32'h00123456, 1'b0, 0};
    vt[1] = '{16'd3, 16'd1, 16'd4, 16'd2, 24'habcdef, 20'h00100, 1, 20'h00107, 32'h00abcdef, 1'b0, 1};
    vt[2] = '{16'd8, 16'd0, 16'd8, 16'd8, 24'h111111, 20'h00080, 0, 20'h0, 32'h0, 1'b1, 0};
    vt[3] = '{16'd0, 16'd8, 16'd8, 16'd8, 24'h222222, 20'h00080, 0, 20'h0, 32'h0, 1'b1, 0};
    vt[4] = '{16'd0, 16'd0, 16'd0, 16'd0, 24'h333333, 20'h00080, 0, 20'h0, 32'h0, 1'b1, 0};
    vt[5] = '{16'h20, 16'd1, 16'h100, 16'h100, 24'hff00a5, 20'hffff0, 1, 20'h00110, 32'h00ff00a5, 1'b0, 0};
    vt[6] = '{16'hfffe, 16'd1, 16'hffff, 16'd2, 24'h010203, 20'h00000, 1, 20'h1fffd, 32'h00010203, 1'b0, 1};

    repeat (3) step();
    check("reset_flags", {MemReq, FrameDone, Overflow, RangeErr, Busy}, 0);
    check("reset_addr_data", {MemAddr, MemData}, 0);
    check("reset_count", PixelCount, 0);
    rst = 1'b1;
    step();

    // single-pixel latency: request appears on the third edge after capture
    MemAck = 1'b1;
    BaseAddr = 20'h01000;
    send(16'd3, 16'd2, 16'd16, 16'd16, 24'h123456);
    step();
    check("lat_e1", MemReq, 0);
    step();
    check("lat_e2", MemReq, 0);
    step();
    check("lat_e3_req", MemReq, 1);
    check("lat_e3_addr", MemAddr, 20'h01023);
    check("lat_e3_data", MemData, 32'h00123456);
    step();
    check("lat_drop", MemReq, 0);
    check("lat_count", PixelCount, 1);

    for (int i = 0; i < 7; i++) begin
      clear_status();
      clear_logs();
      BaseAddr = vt[i].base;
      send(vt[i].x, vt[i].y, vt[i].w, vt[i].h, vt[i].rgb);
      wait_idle(20);
      check($sformatf("v%0d_nwr", i), wa.size(), vt[i].nwr);
      if (vt[i].nwr > 0) begin
        check($sformatf("v%0d_addr", i), wa.size() > 0 ? wa[0] : 20'hx, vt[i].addr);
        check($sformatf("v%0d_data", i), wd.size() > 0 ? wd[0] : 32'hx, vt[i].data);
      end
      check($sformatf("v%0d_rerr", i), RangeErr, vt[i].rerr);
      check($sformatf("v%0d_count", i), PixelCount, vt[i].nwr);
      check($sformatf("v%0d_nfd", i), fd.size(), vt[i].nfd);
    end

    // full 4x2 frame, back-to-back strobes
    clear_status();
    clear_logs();
    BaseAddr = 20'h00200;
    for (int i = 0; i < 8; i++) send(16'(i % 4), 16'(i / 4), 16'd4, 16'd2, {8'(i), 16'h1122});
    wait_idle(30);
    check("frame_nwr", wa.size(), 8);
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      check($sformatf("frame_addr%0d", i), wa[i], 20'h00200 + 20'(i));
      check($sformatf("frame_data%0d", i), wd[i], {8'h00, 8'(i), 16'h1122});
      check($sformatf("frame_cyc%0d", i), wc[i] - wc[0], i);
    end
    check("frame_nfd", fd.size(), 1);
    check("frame_fd_cyc", fd.size() > 0 && wc.size() == 8 ? fd[0] - wc[7] : -1, 1);
    check("frame_count", PixelCount, 8);
    check("frame_busy", Busy, 0);

    // stall: one entry on the port, 16 queued, 3 dropped
    MemAck = 1'b0;
    clear_status();
    clear_logs();
    BaseAddr = 20'h0;
    for (int i = 0; i < 20; i++) send(16'(i), 16'd0, 16'd32, 16'd32, 24'h0a0b0c);
    repeat (5) step();
    check("stall_req", MemReq, 1);
    check("stall_addr", MemAddr, 0);
    check("stall_ovf", Overflow, 1);
    check("stall_count", PixelCount, 0);
    MemAck = 1'b1;
    wait_idle(60);
    check("stall_nwr", wa.size(), 17);
    for (int i = 0; i < wa.size(); i++) check($sformatf("stall_addr%0d", i), wa[i], 20'(i));
    check("stall_count2", PixelCount, 17);

    // out-of-range pixel, then ClearStatus
    send(16'd8, 16'd0, 16'd8, 16'd8, 24'h445566);
    wait_idle(20);
    check("range_err", RangeErr, 1);
    check("range_count", PixelCount, 17);
    check("range_nwr", wa.size(), 17);
    clear_status();
    check("clr_rerr", RangeErr, 0);
    check("clr_ovf", Overflow, 0);
    check("clr_count", PixelCount, 0);

    // ClearStatus on the same edge as a range-error set: the set wins
    send(16'd9, 16'd0, 16'd8, 16'd8, 24'h000000);
    step();
    ClearStatus = 1'b1;
    step();
    ClearStatus = 1'b0;
    check("clr_vs_set", RangeErr, 1);
    wait_idle(20);
    clear_status();

    // reset mid-operation
    MemAck = 1'b0;
    clear_logs();
    for (int i = 0; i < 5; i++) send(16'(i), 16'd0, 16'd8, 16'd8, 24'h777777);
    repeat (4) step();
    check("rst_pre_req", MemReq, 1);
    rst = 1'b0;
    #1;
    check("rst_async_flags", {MemReq, FrameDone, Overflow, RangeErr, Busy}, 0);
    check("rst_async_addr_data", {MemAddr, MemData}, 0);
    check("rst_async_count", PixelCount, 0);
    repeat (2) step();
    rst = 1'b1;
    step();
    MemAck = 1'b1;
    BaseAddr = 20'h03000;
    send(16'd0, 16'd0, 16'd4, 16'd4, 24'h010101);
    wait_idle(20);
    check("rst_post_nwr", wa.size(), 1);
    check("rst_post_addr", wa.size() > 0 ? wa[0] : 20'hx, 20'h03000);
    check("rst_post_count", PixelCount, 1);

    // ack while idle is ignored
    clear_status();
    MemAck = 1'b1;
    repeat (3) step();
    MemAck = 1'b0;
    check("idle_ack_count", PixelCount, 0);

    // random ack gaps; the hold watch checks stability
    clear_logs();
    BaseAddr = 20'h00040;
    for (int i = 0; i < 6; i++) send(16'(i), 16'd0, 16'd8, 16'd8, {8'(i), 16'h5050});
    for (int n = 0; n < 100 && Busy; n++) begin
      MemAck = 1'($urandom_range(0, 1));
      step();
    end
    MemAck = 1'b1;
    wait_idle(20);
    check("gap_nwr", wa.size(), 6);
    for (int i = 0; i < wa.size(); i++) begin
      check($sformatf("gap_addr%0d", i), wa[i], 20'h00040 + 20'(i));
      check($sformatf("gap_data%0d", i), wd[i], {8'h00, 8'(i), 16'h5050});
    end
    check("gap_count", PixelCount, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
